// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the LEGv8 pipelined control unit.
// Holds the opcode match patterns (with '?' wildcards for casez), the ALU
// operation codes and the per-stage control bundles with their bubble values.
package cpu_ctrl_pkg;

  // ALU operation codes driven to the EX stage
  localparam logic [2:0] ALUOP_PASSB = 3'b000;
  localparam logic [2:0] ALUOP_SHIFT = 3'b001;
  localparam logic [2:0] ALUOP_ADD   = 3'b010;
  localparam logic [2:0] ALUOP_SUB   = 3'b011;
  localparam logic [2:0] ALUOP_MUL   = 3'b111;

  // Opcode patterns on instr[31:21]; low bits of the shorter encodings are wildcards
  localparam logic [10:0] OP_ADDI = 11'b1001000100?;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100???;
  localparam logic [10:0] OP_BLT  = 11'b01010100???;
  localparam logic [10:0] OP_B    = 11'b000101?????;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alusrc;
    logic       shiftdir;
    logic       flagen;
    logic       brsel;
    logic       branch;
    logic       ubranch;
  } ex_ctrl_t;

  typedef struct packed {
    logic read;
    logic write;
  } mem_ctrl_t;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  localparam ex_ctrl_t  EX_BUBBLE  = '0;
  localparam mem_ctrl_t MEM_BUBBLE = '0;
  localparam wb_ctrl_t  WB_BUBBLE  = '0;

endpackage

// File: rtl/ctrl_decoder.sv
// Pure combinational opcode decoder for the LEGv8 subset.
// Ports:
//   opcode_i    instr[31:21]
//   ex_o        EX-stage control bundle
//   mem_o       MEM-stage control bundle
//   wb_o        WB-stage control bundle
//   reg2loc_o   register-file port 2 select (1 = Rd/Rt, 0 = Rm)
//   uses_rn_o   instruction reads Rn
//   uses_r2_o   instruction reads register-file port 2
//   illegal_o   opcode matches no supported instruction
// Every field not set by a matching instruction stays 0, so an unknown opcode
// yields an all-zero bubble rather than X.
module ctrl_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  output ex_ctrl_t    ex_o,
  output mem_ctrl_t   mem_o,
  output wb_ctrl_t    wb_o,
  output logic        reg2loc_o,
  output logic        uses_rn_o,
  output logic        uses_r2_o,
  output logic        illegal_o
);

  // Start from a bubble and set only what each instruction needs
  always_comb begin
    ex_o      = EX_BUBBLE;
    mem_o     = MEM_BUBBLE;
    wb_o      = WB_BUBBLE;
    reg2loc_o = 1'b0;
    uses_rn_o = 1'b0;
    uses_r2_o = 1'b0;
    illegal_o = 1'b0;
    casez (opcode_i)
      OP_ADDI: begin
        ex_o.aluop  = ALUOP_ADD;
        ex_o.alusrc = 1'b1;
        wb_o.regwrite = 1'b1;
        uses_rn_o   = 1'b1;
      end
      OP_ADDS, OP_SUBS: begin
        ex_o.aluop  = (opcode_i == OP_SUBS) ? ALUOP_SUB : ALUOP_ADD;
        ex_o.flagen = 1'b1;
        wb_o.regwrite = 1'b1;
        uses_rn_o   = 1'b1;
        uses_r2_o   = 1'b1;
      end
      OP_MUL: begin
        ex_o.aluop  = ALUOP_MUL;
        wb_o.regwrite = 1'b1;
        uses_rn_o   = 1'b1;
        uses_r2_o   = 1'b1;
      end
      // Shift amount comes from the immediate field, hence alusrc
      OP_LSL, OP_LSR: begin
        ex_o.aluop    = ALUOP_SHIFT;
        ex_o.alusrc   = 1'b1;
        ex_o.shiftdir = (opcode_i == OP_LSR);
        wb_o.regwrite = 1'b1;
        uses_rn_o     = 1'b1;
      end
      OP_LDUR: begin
        ex_o.aluop    = ALUOP_ADD;
        ex_o.alusrc   = 1'b1;
        mem_o.read    = 1'b1;
        wb_o.regwrite = 1'b1;
        wb_o.memtoreg = 1'b1;
        uses_rn_o     = 1'b1;
      end
      // Store data (Rt) is read through port 2
      OP_STUR: begin
        ex_o.aluop  = ALUOP_ADD;
        ex_o.alusrc = 1'b1;
        mem_o.write = 1'b1;
        reg2loc_o   = 1'b1;
        uses_rn_o   = 1'b1;
        uses_r2_o   = 1'b1;
      end
      // CBZ passes Rt through the ALU to test it for zero
      OP_CBZ: begin
        ex_o.aluop  = ALUOP_PASSB;
        ex_o.branch = 1'b1;
        reg2loc_o   = 1'b1;
        uses_r2_o   = 1'b1;
      end
      OP_BLT: begin
        ex_o.branch = 1'b1;
        ex_o.brsel  = 1'b1;
      end
      OP_B: begin
        ex_o.ubranch = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode stage plus EX/MEM/WB control pipeline for the pipelined LEGv8 CPU.
// Ports:
//   clk, reset_n                clock and synchronous active-low reset
//   id_valid, id_opcode         live instruction in ID and its opcode
//   id_rn, id_rm, id_rd         register fields of the ID instruction
//   br_taken                    branch taken in EX; kills the ID instruction
//   stall_ext                   freezes every pipeline register
//   id_reg2loc                  comb register-file port 2 select
//   stall                       comb hold request for PC and IF/ID
//   illegal                     registered pulse for an accepted bad opcode
//   ex_* / mem_* / wb_*         registered per-stage control outputs
module pipelined_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 3,
  parameter int FLAG_FWD = 1,
  parameter int ZERO_REG = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [10:0]        id_opcode,
  input  logic [REG_AW-1:0]  id_rn,
  input  logic [REG_AW-1:0]  id_rm,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               br_taken,
  input  logic               stall_ext,
  output logic               id_reg2loc,
  output logic               stall,
  output logic               illegal,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic               ex_alusrc,
  output logic               ex_shiftdir,
  output logic               ex_flagen,
  output logic               ex_brsel,
  output logic               ex_branch,
  output logic               ex_ubranch,
  output logic               mem_valid,
  output logic               mem_read,
  output logic               mem_write,
  output logic               wb_valid,
  output logic               wb_regwrite,
  output logic               wb_memtoreg,
  output logic [REG_AW-1:0]  wb_rd
);

  ex_ctrl_t  dec_ex;
  mem_ctrl_t dec_mem;
  wb_ctrl_t  dec_wb;
  logic      dec_reg2loc, dec_uses_rn, dec_uses_r2, dec_illegal;

  ctrl_decoder u_dec (
    .opcode_i  (id_opcode),
    .ex_o      (dec_ex),
    .mem_o     (dec_mem),
    .wb_o      (dec_wb),
    .reg2loc_o (dec_reg2loc),
    .uses_rn_o (dec_uses_rn),
    .uses_r2_o (dec_uses_r2),
    .illegal_o (dec_illegal)
  );

  // EX stage carries its own MEM/WB groups and rd onward
  logic              ex_valid_q, ex_valid_d;
  ex_ctrl_t          ex_ctrl_q, ex_ctrl_d;
  mem_ctrl_t         ex_mem_q, ex_mem_d;
  wb_ctrl_t          ex_wb_q, ex_wb_d;
  logic [REG_AW-1:0] ex_rd_q, ex_rd_d;

  logic              mem_valid_q;
  mem_ctrl_t         mem_ctrl_q;
  wb_ctrl_t          mem_wb_q;
  logic [REG_AW-1:0] mem_rd_q;

  logic              wb_valid_q;
  wb_ctrl_t          wb_ctrl_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic              illegal_q, illegal_d;

  logic [REG_AW-1:0] r2_idx;
  logic              load_in_ex, load_hazard, flag_hazard, hazard, accept;

  // A load in EX cannot forward to ID; XZR writes are discarded so never conflict.
  // The flag hazard only exists when BLT cannot see flags produced in EX.
  always_comb begin
    r2_idx      = dec_reg2loc ? id_rd : id_rm;
    load_in_ex  = ex_valid_q & ex_mem_q.read & (ex_rd_q != REG_AW'(ZERO_REG));
    load_hazard = id_valid & load_in_ex &
                  ((dec_uses_rn & (id_rn == ex_rd_q)) |
                   (dec_uses_r2 & (r2_idx == ex_rd_q)));
    flag_hazard = (FLAG_FWD == 0) & id_valid & dec_ex.brsel &
                  ex_valid_q & ex_ctrl_q.flagen;
    hazard      = load_hazard | flag_hazard;
    accept      = id_valid & ~dec_illegal & ~br_taken & ~hazard;
    ex_valid_d  = accept;
    ex_ctrl_d   = accept ? dec_ex  : EX_BUBBLE;
    ex_mem_d    = accept ? dec_mem : MEM_BUBBLE;
    ex_wb_d     = accept ? dec_wb  : WB_BUBBLE;
    ex_rd_d     = accept ? id_rd   : '0;
    illegal_d   = id_valid & dec_illegal & ~br_taken;
  end

  // Stage registers: reset clears everything, stall_ext freezes the pipe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= EX_BUBBLE;
      ex_mem_q    <= MEM_BUBBLE;
      ex_wb_q     <= WB_BUBBLE;
      ex_rd_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_ctrl_q  <= MEM_BUBBLE;
      mem_wb_q    <= WB_BUBBLE;
      mem_rd_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_ctrl_q   <= WB_BUBBLE;
      wb_rd_q     <= '0;
      illegal_q   <= 1'b0;
    end else if (stall_ext) begin
      illegal_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_mem_q    <= ex_mem_d;
      ex_wb_q     <= ex_wb_d;
      ex_rd_q     <= ex_rd_d;
      mem_valid_q <= ex_valid_q;
      mem_ctrl_q  <= ex_mem_q;
      mem_wb_q    <= ex_wb_q;
      mem_rd_q    <= ex_rd_q;
      wb_valid_q  <= mem_valid_q;
      wb_ctrl_q   <= mem_wb_q;
      wb_rd_q     <= mem_rd_q;
      illegal_q   <= illegal_d;
    end
  end

  assign id_reg2loc  = dec_reg2loc;
  assign stall       = hazard & ~br_taken & ~stall_ext;
  assign illegal     = illegal_q;
  assign ex_valid    = ex_valid_q;
  assign ex_aluop    = ALUOP_W'(ex_ctrl_q.aluop);
  assign ex_alusrc   = ex_ctrl_q.alusrc;
  assign ex_shiftdir = ex_ctrl_q.shiftdir;
  assign ex_flagen   = ex_ctrl_q.flagen;
  assign ex_brsel    = ex_ctrl_q.brsel;
  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_ubranch  = ex_ctrl_q.ubranch;
  assign mem_valid   = mem_valid_q;
  assign mem_read    = mem_ctrl_q.read;
  assign mem_write   = mem_ctrl_q.write;
  assign wb_valid    = wb_valid_q;
  assign wb_regwrite = wb_ctrl_q.regwrite;
  assign wb_memtoreg = wb_ctrl_q.memtoreg;
  assign wb_rd       = wb_rd_q;

endmodule
